// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: shared AXI4-Lite response codes and channel state encodings for the register file
package axi4lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/axi4lite_regbank.sv
// axi4lite_regbank: NREG x 8N storage; ports Clk/Rst, byte-strobe write port (we, widx, wdata, wstrb), flat regs_o
module axi4lite_regbank
  import axi4lite_pkg::*;
#(
  parameter int N = 4,
  parameter int NREG = 8,
  localparam int IB = $clog2(NREG)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  we,
  input  logic [IB-1:0]         widx,
  input  logic [8*N-1:0]        wdata,
  input  logic [N-1:0]          wstrb,
  output logic [NREG*8*N-1:0]   regs_o
);
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) regs_o <= '0;
    else if (we)
      for (int k = 0; k < NREG; k++)
        for (int i = 0; i < N; i++)
          if (widx == IB'(k) && wstrb[i]) regs_o[k*8*N + i*8 +: 8] <= wdata[i*8 +: 8];
endmodule

// File: rtl/axi4lite_regfile.sv
// axi4lite_regfile: AXI4-Lite slave over NREG registers; ports Clk/Rst, AW/W/B and AR/R channels, flat regs_o
module axi4lite_regfile
  import axi4lite_pkg::*;
#(
  parameter int N = 4,
  parameter int A = 32,
  parameter int NREG = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [A-1:0]          AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [8*N-1:0]        WDATA,
  input  logic [N-1:0]          WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [A-1:0]          ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [8*N-1:0]        RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [NREG*8*N-1:0]   regs_o
);
  localparam int W = 8*N;
  localparam int OB = $clog2(N);
  localparam int IB = $clog2(NREG);
  localparam logic [A-1:0] LIM = A'(NREG*N);
  wstate_t wst;
  rstate_t rs;
  logic aw_got, w_got, aw_hs, w_hs, have_aw, have_w, commit, w_ok, r_ok;
  logic [A-1:0] aw_addr, c_addr;
  logic [W-1:0] w_data, c_data;
  logic [N-1:0] w_strb, c_strb;
  logic [W-1:0] words [NREG];
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};
  for (genvar k = 0; k < NREG; k++) begin : g_w
    assign words[k] = regs_o[k*W +: W];
  end
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign have_aw = aw_got || aw_hs;
  assign have_w = w_got || w_hs;
  assign c_addr = aw_got ? aw_addr : AWADDR;
  assign c_data = w_got ? w_data : WDATA;
  assign c_strb = w_got ? w_strb : WSTRB;
  assign commit = wst == W_IDLE && have_aw && have_w;
  assign w_ok = c_addr < LIM;
  assign r_ok = ARADDR < LIM;
  axi4lite_regbank #(.N(N), .NREG(NREG)) u_bank (
    .Clk(Clk), .Rst(Rst), .we(commit && w_ok), .widx(c_addr[OB +: IB]),
    .wdata(c_data), .wstrb(c_strb), .regs_o(regs_o)
  );
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      wst <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      AWREADY <= 1'b0;
      WREADY <= 1'b0;
      BVALID <= 1'b0;
      BRESP <= OKAY;
    end else if (wst == W_IDLE) begin
      if (aw_hs) aw_addr <= AWADDR;
      if (w_hs) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
        AWREADY <= 1'b0;
        WREADY <= 1'b0;
        BVALID <= 1'b1;
        BRESP <= w_ok ? OKAY : SLVERR;
        wst <= W_RESP;
      end else begin
        aw_got <= have_aw;
        w_got <= have_w;
        AWREADY <= !have_aw;
        WREADY <= !have_w;
      end
    end else if (BREADY) begin
      BVALID <= 1'b0;
      AWREADY <= 1'b1;
      WREADY <= 1'b1;
      wst <= W_IDLE;
    end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      rs <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID <= 1'b0;
      RDATA <= '0;
      RRESP <= OKAY;
    end else if (rs == R_IDLE) begin
      if (ARVALID && ARREADY) begin
        RDATA <= r_ok ? words[ARADDR[OB +: IB]] : '0;
        RRESP <= r_ok ? OKAY : SLVERR;
        RVALID <= 1'b1;
        ARREADY <= 1'b0;
        rs <= R_DATA;
      end else ARREADY <= 1'b1;
    end else if (RREADY) begin
      RVALID <= 1'b0;
      ARREADY <= 1'b1;
      rs <= R_IDLE;
    end
endmodule

// File: tb/tb_axi4lite_regfile.sv
// tb_axi4lite_regfile: randomized self-checking bench for axi4lite_regfile against an array model of the registers
module tb_axi4lite_regfile;
  logic Clk = 0;
  logic Rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0] AWPROT, ARPROT;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [255:0] regs_o;
  logic [31:0] mdl [8];
  int errors = 0;
  int checks = 0;
  always #5 Clk = ~Clk;
  axi4lite_regfile #(.N(4), .A(32), .NREG(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );
  function automatic logic [255:0] mdl_flat();
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = mdl[k];
    return f;
  endfunction
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return a < 32 ? 2'b00 : 2'b10;
  endfunction
  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a < 32)
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[a / 4][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    logic ha, hw;
    int t;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    t = 0;
    while ((AWVALID || WVALID) && t < 50) begin
      @(negedge Clk);
      ha = AWVALID && AWREADY;
      hw = WVALID && WREADY;
      @(posedge Clk); #1;
      if (ha) AWVALID = 0;
      if (hw) WVALID = 0;
      t++;
    end
    @(negedge Clk);
    while (!BVALID && t < 50) begin
      @(negedge Clk);
      t++;
    end
    r = BRESP;
    if (t >= 50) begin
      errors++; checks++;
      $display("FAIL write_timeout: addr %h no B response within 50 cycles", a);
      AWVALID = 0; WVALID = 0;
    end
    @(posedge Clk); #1;
  endtask
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    logic h;
    int t;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    t = 0;
    while (ARVALID && t < 50) begin
      @(negedge Clk);
      h = ARREADY;
      @(posedge Clk); #1;
      if (h) ARVALID = 0;
      t++;
    end
    @(negedge Clk);
    while (!RVALID && t < 50) begin
      @(negedge Clk);
      t++;
    end
    d = RDATA; r = RRESP;
    if (t >= 50) begin
      errors++; checks++;
      $display("FAIL read_timeout: addr %h no R response within 50 cycles", a);
      ARVALID = 0;
    end
    @(posedge Clk); #1;
  endtask
  task automatic test_reset();
    Rst = 0;
    AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
    for (int k = 0; k < 8; k++) mdl[k] = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if ({regs_o, RDATA, RRESP, BRESP} !== '0) begin
      errors++; $display("FAIL reset_data: regs %h rdata %h rresp %b bresp %b want all 0", regs_o, RDATA, RRESP, BRESP);
    end
    @(posedge Clk); #1;
    Rst = 1;
    @(negedge Clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    @(negedge Clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    @(posedge Clk); #1;
  endtask
  task automatic test_strobe();
    logic [1:0] r;
    logic [31:0] d;
    do_write(32'h04, 32'h12345678, 4'b1011, r);
    mdl_write(32'h04, 32'h12345678, 4'b1011);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strobe_bresp: got %b want 00", r); end
    checks++;
    if (regs_o[63:32] !== 32'h12005678) begin errors++; $display("FAIL strobe_regs: got %h want 12005678", regs_o[63:32]); end
    do_read(32'h04, d, r);
    checks++;
    if (d !== 32'h12005678 || r !== 2'b00) begin errors++; $display("FAIL strobe_read: got %h/%b want 12005678/00", d, r); end
  endtask
  task automatic test_oob();
    logic [1:0] r;
    logic [31:0] d;
    do_write(32'h40, 32'hDEADBEEF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL oob_bresp: got %b want 10", r); end
    checks++;
    if (regs_o !== mdl_flat()) begin errors++; $display("FAIL oob_regs: got %h want %h", regs_o, mdl_flat()); end
    do_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oob_read: got %h/%b want 00000000/10", d, r); end
  endtask
  task automatic test_w_first();
    logic [1:0] r;
    logic [31:0] d;
    WDATA = 32'h0000ABCD; WSTRB = 4'hF; WVALID = 1;
    @(negedge Clk);
    checks++;
    if (WREADY !== 1'b1) begin errors++; $display("FAIL wfirst_wready_idle: got %b want 1", WREADY); end
    @(posedge Clk); #1;
    WVALID = 0;
    repeat (2) begin
      @(negedge Clk);
      checks++;
      if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
        errors++; $display("FAIL wfirst_held: wready %b bvalid %b want 0 0", WREADY, BVALID);
      end
      @(posedge Clk); #1;
    end
    AWADDR = 32'h1C; AWVALID = 1; BREADY = 1;
    @(negedge Clk);
    checks++;
    if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_aw: awready %b bvalid %b want 1 0", AWREADY, BVALID); end
    @(posedge Clk); #1;
    AWVALID = 0;
    @(negedge Clk);
    mdl_write(32'h1C, 32'h0000ABCD, 4'hF);
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin errors++; $display("FAIL wfirst_b: bvalid %b bresp %b want 1 00", BVALID, BRESP); end
    checks++;
    if (regs_o !== mdl_flat()) begin errors++; $display("FAIL wfirst_regs: got %h want %h", regs_o, mdl_flat()); end
    @(posedge Clk); #1;
    do_read(32'h1C, d, r);
    checks++;
    if (d !== 32'h0000ABCD || r !== 2'b00) begin errors++; $display("FAIL wfirst_read: got %h/%b want 0000abcd/00", d, r); end
  endtask
  task automatic test_backpressure();
    logic [1:0] r;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    AWADDR = 32'h0C; WDATA = d1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(negedge Clk);
    @(posedge Clk); #1;
    mdl_write(32'h0C, d1, 4'hF);
    AWADDR = 32'h10; WDATA = d2; WSTRB = 4'hF;
    repeat (5) begin
      @(negedge Clk);
      checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++; $display("FAIL bp_hold: bvalid %b bresp %b awready %b wready %b want 1 00 0 0", BVALID, BRESP, AWREADY, WREADY);
      end
      checks++;
      if (regs_o !== mdl_flat()) begin errors++; $display("FAIL bp_regs: got %h want %h", regs_o, mdl_flat()); end
      @(posedge Clk); #1;
    end
    do_write(32'h10, d2, 4'hF, r);
    mdl_write(32'h10, d2, 4'hF);
    checks++;
    if (r !== 2'b00 || regs_o !== mdl_flat()) begin
      errors++; $display("FAIL bp_second: resp %b regs %h want 00 %h", r, regs_o, mdl_flat());
    end
  endtask
  task automatic test_same_cycle();
    logic [1:0] r;
    logic [31:0] d;
    do_write(32'h08, 32'h11111111, 4'hF, r);
    mdl_write(32'h08, 32'h11111111, 4'hF);
    AWADDR = 32'h08; WDATA = 32'h22222222; WSTRB = 4'hF; ARADDR = 32'h08;
    AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 1; RREADY = 1;
    @(negedge Clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL same_ready: got %b want 111", {AWREADY, WREADY, ARREADY}); end
    @(posedge Clk); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge Clk);
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h11111111) begin errors++; $display("FAIL same_old: rvalid %b rdata %h want 1 11111111", RVALID, RDATA); end
    checks++;
    if (BVALID !== 1'b1 || regs_o[95:64] !== 32'h22222222) begin errors++; $display("FAIL same_commit: bvalid %b reg2 %h want 1 22222222", BVALID, regs_o[95:64]); end
    mdl_write(32'h08, 32'h22222222, 4'hF);
    @(posedge Clk); #1;
    do_read(32'h08, d, r);
    checks++;
    if (d !== 32'h22222222) begin errors++; $display("FAIL same_new: got %h want 22222222", d); end
  endtask
  task automatic test_random();
    logic [1:0] r;
    logic [31:0] a, d, rd;
    logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 63); d = $urandom; s = 4'($urandom_range(0, 15));
      do_write(a, d, s, r);
      mdl_write(a, d, s);
      checks++;
      if (r !== exp_resp(a)) begin errors++; $display("FAIL rand_bresp: addr %h got %b want %b", a, r, exp_resp(a)); end
      checks++;
      if (regs_o !== mdl_flat()) begin errors++; $display("FAIL rand_regs: got %h want %h", regs_o, mdl_flat()); end
      a = $urandom_range(0, 63);
      do_read(a, rd, r);
      checks++;
      if (r !== exp_resp(a) || rd !== (a < 32 ? mdl[a / 4] : 32'h0)) begin
        errors++; $display("FAIL rand_read: addr %h got %h/%b want %h/%b", a, rd, r, a < 32 ? mdl[a / 4] : 32'h0, exp_resp(a));
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [1:0] r;
    logic [31:0] d;
    AWADDR = 32'h00; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; ARADDR = 32'h14;
    AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
    @(negedge Clk);
    @(posedge Clk); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge Clk);
    checks++;
    if (BVALID !== 1'b1 || RVALID !== 1'b1) begin errors++; $display("FAIL rmid_pre: bvalid %b rvalid %b want 1 1", BVALID, RVALID); end
    Rst = 0;
    #1;
    for (int k = 0; k < 8; k++) mdl[k] = 0;
    checks++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b0 || regs_o !== '0) begin
      errors++; $display("FAIL rmid_async: ctrl %b regs %h want 00000 0", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, regs_o);
    end
    @(posedge Clk); #1;
    Rst = 1; BREADY = 1; RREADY = 1;
    @(negedge Clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin errors++; $display("FAIL rmid_ready0: got %b want 000", {AWREADY, WREADY, ARREADY}); end
    @(negedge Clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      errors++; $display("FAIL rmid_ready1: got %b want 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    @(posedge Clk); #1;
    do_write(32'h18, 32'h0BADF00D, 4'b0110, r);
    mdl_write(32'h18, 32'h0BADF00D, 4'b0110);
    do_read(32'h18, d, r);
    checks++;
    if (d !== mdl[6] || r !== 2'b00) begin errors++; $display("FAIL rmid_after: got %h/%b want %h/00", d, r, mdl[6]); end
  endtask
  initial begin
    test_reset();
    test_strobe();
    test_oob();
    test_w_first();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4lite_regfile.md
# axi4lite_regfile

Synthesizable AXI4-Lite slave that exposes a bank of NREG control/status registers to an AXI4-Lite master. It answers write and read transactions with OKAY or SLVERR and drives every register as a flat output vector for downstream logic. Writes honour byte strobes. It connects to the same AXI4-Lite interface the master BFM drives, and replaces the behavioural slave BFM in benches that need real RTL behind the bus.

## Interface
- N, 4: data bus width in bytes (4 or 8).
- A, 32: address width in bits.
- NREG, 8: number of registers; a power of two and at least 2.
- Clk  in  1  clock; all logic is on the rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- AWADDR  in  A  write address.
- AWPROT  in  3  accepted and ignored.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  8N  write data.
- WSTRB  in  N  byte strobes.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  A  read address.
- ARPROT  in  3  accepted and ignored.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  8N  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1  read-data handshake.
- regs_o  out  NREG*8N  register contents; register k sits at bits [k*8N +: 8N].

## Operation
- Address decode:
  - Word index = ADDR[log2(N) +: log2(NREG)].
  - In range when ADDR < NREG*N. Out of range gives SLVERR (2'b10).
  - Low log2(N) bits are ignored, so unaligned addresses round down.
- Write channel state machine: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are captured independently into holding registers. A captured channel drops its READY.
  - The cycle in which the second of AW and W is captured (or both in the same cycle) commits the write:
    - register bytes with WSTRB[i]=1 update; other bytes are unchanged;
    - BRESP is set to OKAY, or to SLVERR with no register change if out of range;
    - BVALID is set and the machine moves to W_RESP.
  - W_RESP: BVALID is held with a stable BRESP until BREADY. On the handshake: BVALID=0, AWREADY=WREADY=1, return to W_IDLE.
- Read channel state machine: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On the handshake:
    - RDATA is loaded with the register value, or 0 if out of range;
    - RRESP is loaded with OKAY or SLVERR;
    - RVALID=1, ARREADY=0, move to R_DATA.
  - R_DATA: RDATA, RRESP and RVALID are held until RREADY. Then RVALID=0, ARREADY=1, return to R_IDLE.
- Read and write channels are fully independent.
  - If a read handshake and a write commit hit the same register in the same cycle, the read returns the pre-write value.
- WSTRB=0 gives an OKAY response and no change to any register.

## Timing
- Reset (Rst=0, asynchronous):
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are 0.
  - BRESP, RRESP and RDATA are 0, and every register is 0.
  - Both state machines return to their IDLE state, even mid-transaction; captured AW/W data is discarded.
- AWREADY, WREADY and ARREADY rise on the first Clk edge after Rst deasserts.
- All outputs are registered; there is no combinational path from input to output.
- Write latency: BVALID rises 1 cycle after the last AW/W handshake. regs_o shows the new value in the same cycle as BVALID.
- Read latency: RVALID rises 1 cycle after the AR handshake.
- Throughput:
  - one write per 2 cycles with BREADY tied high;
  - one read per 2 cycles with RREADY tied high.
- No new AW or W is accepted while BVALID=1. No new AR is accepted while RVALID=1.

## Structure
- Shared package axi4lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - wstate_t (W_IDLE, W_RESP) and rstate_t (R_IDLE, R_DATA).
- One sub-module, axi4lite_regbank, holds the NREG x 8N storage with a byte-strobe write port, an async-reset clear and the flat regs_o output.
- Both handshake state machines stay in the top module.

## Test plan
- Write 0x04 with data 0x12345678 and WSTRB 4'b1011, then read 0x04 -> BRESP=OKAY, RDATA=0x12005678, regs_o[63:32]=0x12005678.
- Write 0x40 with data 0xDEADBEEF (out of range), then read 0x40 -> BRESP=SLVERR, all registers unchanged, RDATA=0, RRESP=SLVERR.
- W presented 3 cycles before AW, write 0x1C with data 0x0000ABCD and WSTRB 4'hF:
  - WREADY=0 after W is captured;
  - BVALID rises 1 cycle after the AW handshake;
  - register 7 reads 0x0000ABCD.
- BREADY held low for 5 cycles with a second AW/W pending -> BVALID and BRESP stay stable and AWREADY/WREADY stay 0; the second write commits only after the B handshake.
- Write commit to 0x08 and read of 0x08 in the same cycle, old value 0x11111111, new value 0x22222222 -> RDATA=0x11111111; a following read returns 0x22222222.
- Rst pulsed low while RVALID=1 and BVALID=1 -> both drop to 0 immediately, all regs_o=0, READY signals return 1 cycle after Rst deasserts.
